// File: rtl/multi_rate_clk_gen_if.sv
// Config/enable/sync inputs and tick/divided-clock outputs of the multi-rate clock-enable generator.
// The master side drives configuration; the slave side is the generator itself.
interface multi_rate_clk_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] div_clk;
    logic              aligned;

    modport master (
        output cfg_we, cfg_ch, cfg_div, ch_en, sync,
        input  tick, div_clk, aligned
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, ch_en, sync,
        output tick, div_clk, aligned
    );
endinterface

// File: rtl/multi_rate_clk_gen.sv
// NUM_CH programmable clock-enable dividers: registered tick, 50% div_clk and aligned flag (1-cycle latency).
// No backpressure; new divisors wait in a pending register until terminal count, channel disable or sync.
module multi_rate_clk_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input logic                clk,
    input logic                rst_n,
    multi_rate_clk_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CNT_W-1:0]  active_q [NUM_CH];
    logic [CNT_W-1:0]  active_d [NUM_CH];
    logic [CNT_W-1:0]  pend_q   [NUM_CH];
    logic [CNT_W-1:0]  pend_d   [NUM_CH];
    logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] dclk_q, dclk_d;
    logic              aligned_q, aligned_d;

    logic [NUM_CH-1:0] term;
    logic [CNT_W-1:0]  wr_div;
    logic              wr_hit;
    logic [CNT_W-1:0]  new_pend;

    always_comb begin
        cnt_d      = cnt_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        tick_d     = tick_q;
        dclk_d     = dclk_q;
        term       = '0;
        wr_hit     = 1'b0;
        new_pend   = '0;
        wr_div     = (bus.cfg_div == '0) ? ONE : bus.cfg_div;

        for (int i = 0; i < NUM_CH; i++) begin
            // ">=" rather than "==": a divisor shrunk while disabled may leave cnt beyond the new end.
            term[i]  = (cnt_q[i] >= (active_q[i] - ONE));
            wr_hit   = bus.cfg_we && (32'(bus.cfg_ch) == i);
            new_pend = wr_hit ? wr_div : pend_q[i];

            if (bus.sync) begin
                cnt_d[i]      = '0;
                tick_d[i]     = 1'b0;
                dclk_d[i]     = 1'b0;
                active_d[i]   = new_pend;
                pend_d[i]     = new_pend;
                pend_vld_d[i] = 1'b0;
            end else begin
                pend_d[i]     = new_pend;
                pend_vld_d[i] = pend_vld_q[i] | wr_hit;

                // A write landing on the switch edge stays pending for the next boundary.
                if (pend_vld_q[i] && (!bus.ch_en[i] || term[i])) begin
                    active_d[i]   = pend_q[i];
                    pend_vld_d[i] = wr_hit;
                end

                if (bus.ch_en[i]) begin
                    if (term[i]) begin
                        cnt_d[i]  = '0;
                        tick_d[i] = 1'b1;
                        dclk_d[i] = ~dclk_q[i];
                    end else begin
                        cnt_d[i]  = cnt_q[i] + ONE;
                        tick_d[i] = 1'b0;
                    end
                end else begin
                    tick_d[i] = 1'b0;
                end
            end
        end

        aligned_d = !bus.sync && (|bus.ch_en) && (&(term | ~bus.ch_en));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                active_q[i] <= DIV_INIT;
                pend_q[i]   <= DIV_INIT;
            end
            pend_vld_q <= '0;
            tick_q     <= '0;
            dclk_q     <= '0;
            aligned_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                active_q[i] <= active_d[i];
                pend_q[i]   <= pend_d[i];
            end
            pend_vld_q <= pend_vld_d;
            tick_q     <= tick_d;
            dclk_q     <= dclk_d;
            aligned_q  <= aligned_d;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.div_clk = dclk_q;
    assign bus.aligned = aligned_q;

endmodule

// File: tb/tb_multi_rate_clk_gen.sv
// Scoreboard bench for multi_rate_clk_gen: stimulus queues expected per-cycle outputs, a negedge monitor checks them.
module tb_multi_rate_clk_gen;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    typedef struct {
        int          cyc;
        logic [3:0]  tick;
        logic [3:0]  tmask;
        logic [3:0]  dclk;
        logic [3:0]  dmask;
        logic        al;
        logic        amask;
        logic [63:0] name;
    } exp_t;

    exp_t sb[$];

    multi_rate_clk_gen_if #(.NUM_CH(4), .CNT_W(16), .CH_W(3)) bus ();

    multi_rate_clk_gen #(
        .NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(2), .CH_W(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (e.cyc < cyc) begin
                fails++;
                $display("FAIL %s stale record cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else if ((((bus.tick ^ e.tick) & e.tmask) != 4'b0) ||
                         (((bus.div_clk ^ e.dclk) & e.dmask) != 4'b0) ||
                         (((bus.aligned ^ e.al) & e.amask) != 1'b0)) begin
                fails++;
                $display("FAIL %s cyc=%0d got tick=%b dclk=%b al=%b exp tick=%b dclk=%b al=%b (masks %b %b %b)",
                         e.name, cyc, bus.tick, bus.div_clk, bus.aligned,
                         e.tick, e.dclk, e.al, e.tmask, e.dmask, e.amask);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] t, input logic [3:0] tm,
                        input logic [3:0] d, input logic [3:0] dm,
                        input logic a, input logic am, input logic [63:0] nm);
        exp_t e;
        e.cyc = c; e.tick = t; e.tmask = tm; e.dclk = d; e.dmask = dm;
        e.al = a; e.amask = am; e.name = nm;
        sb.push_back(e);
    endtask

    // Expected outputs for n cycles after a restart at cycle s, divisors d0..d3, ticks every D-th cycle.
    task automatic push_run(input int s, input int n, input int d0, input int d1,
                            input int d2, input int d3, input logic [3:0] m,
                            input int lcm, input logic [63:0] nm);
        int         d [4];
        logic [3:0] t;
        logic [3:0] k;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int c = 1; c <= n; c++) begin
            for (int i = 0; i < 4; i++) begin
                t[i] = ((c % d[i]) == 0);
                k[i] = (((c / d[i]) % 2) == 1);
            end
            push(s + c, t, m, k, m, ((c % lcm) == 0), 1'b1, nm);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 5000) begin
            step();
            n++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic cfg_write(input int ch, input int dv);
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = 3'(ch);
        bus.cfg_div = 16'(dv);
        step();
        bus.cfg_we  = 1'b0;
    endtask

    task automatic do_sync(output int s);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        s = cyc;
    endtask

    initial begin
        int r;
        int s;
        logic [3:0] t;
        logic [3:0] k;
        cyc = 0; tests = 0; fails = 0;
        rst_n = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;
        bus.ch_en = 4'b1111; bus.sync = 1'b0;
        #1 rst_n = 1'b0;

        // 1: reset state, default divisor 2, async reset mid-count
        push(2, 4'b0, 4'hf, 4'b0, 4'hf, 1'b0, 1'b1, "rst");
        repeat (3) step();
        rst_n = 1'b1;
        r = cyc;
        push_run(r, 13, 2, 2, 2, 2, 4'hf, 2, "dflt");
        while (cyc < r + 14) step();
        rst_n = 1'b0;
        push(r + 14, 4'b0, 4'hf, 4'b0, 4'hf, 1'b0, 1'b1, "arst");
        step(); step();
        rst_n = 1'b1;
        drain();

        // 2: divisors 1/10/100/1000 after sync
        cfg_write(0, 1); cfg_write(1, 10); cfg_write(2, 100); cfg_write(3, 1000);
        do_sync(s);
        push_run(s, 2000, 1, 10, 100, 1000, 4'hf, 1000, "rates");
        drain();

        // 3: ch1 D=10, reprogram to 4 while cnt=3; old period completes first
        bus.ch_en = 4'b0010;
        cfg_write(1, 10);
        do_sync(s);
        for (int c = 1; c <= 26; c++) begin
            t = '0; k = '0;
            t[1] = (c == 10 || c == 14 || c == 18 || c == 22 || c == 26);
            k[1] = (c >= 10) && ((((c - 10) / 4) % 2) == 0);
            push(s + c, t, 4'b0010, k, 4'b0010, 1'b0, 1'b0, "switch");
        end
        repeat (3) step();
        cfg_write(1, 4);
        drain();

        // 4: ch2 D=5, disabled for 7 edges while cnt=2 and div_clk high
        bus.ch_en = 4'b0100;
        cfg_write(2, 5);
        do_sync(s);
        for (int c = 1; c <= 22; c++) begin
            t = '0; k = '0;
            t[2] = (c == 5 || c == 17 || c == 22);
            k[2] = (c >= 5 && c <= 16) || (c == 22);
            push(s + c, t, 4'b0100, k, 4'b0100, 1'b0, 1'b0, "hold");
        end
        repeat (7) step();
        bus.ch_en = 4'b0000;
        repeat (7) step();
        bus.ch_en = 4'b0100;
        drain();

        // 5: D=3 and D=4 free-running, then a one-cycle sync realigns them
        bus.ch_en = 4'b0011;
        cfg_write(0, 3); cfg_write(1, 4);
        repeat (7) step();
        do_sync(s);
        push_run(s, 24, 3, 4, 1, 1, 4'b0011, 12, "resync");
        drain();

        // 6: div 0 stored as 1, out-of-range channel ignored, write coinciding with sync
        bus.ch_en = 4'b1111;
        cfg_write(0, 0); cfg_write(1, 2); cfg_write(2, 3); cfg_write(4, 7);
        bus.cfg_we = 1'b1; bus.cfg_ch = 3'd3; bus.cfg_div = 16'd5;
        do_sync(s);
        bus.cfg_we = 1'b0;
        push_run(s, 30, 1, 2, 3, 5, 4'hf, 30, "illegal");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
